// File: rtl/pos_to_stepper.sv
// Pen-target consumer: Bresenham line moves on two steppers, pen servo, finish flag.
// Optional: define HOME_RETURN_EN to travel back to (0,0) after the drawing ends.
module pos_to_stepper #(
   parameter int unsigned STEP_DIV   = 50000,
   parameter int unsigned PEN_SETTLE = 5000000,
   parameter int unsigned MAX_COORD  = 449
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iStart,
   output logic       oPOS_REQUEST,
   input  logic [8:0] iX,
   input  logic [8:0] iY,
   input  logic       iDown,
   input  logic       iDone,
   output logic       oStepX,
   output logic       oStepY,
   output logic       oDirX,
   output logic       oDirY,
   output logic       oPen,
   output logic       oBusy,
   output logic       oFinish
);

   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int SW = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   localparam logic [SW-1:0] SET_LAST = SW'(PEN_SETTLE - 1);
   localparam logic [8:0]    MAXC     = 9'(MAX_COORD);

`ifdef HOME_RETURN_EN
   localparam bit HOME = 1'b1;
`else
   localparam bit HOME = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CALC,
      S_PEN,
      S_MOVE,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic              start_q;
   logic [8:0]        tx_q, tx_d;
   logic [8:0]        ty_q, ty_d;
   logic              down_q, down_d;
   logic              fin_q, fin_d;
   logic [8:0]        cx_q, cx_d;
   logic [8:0]        cy_q, cy_d;
   logic signed [9:0] dx_q, dx_d;
   logic signed [9:0] dy_q, dy_d;
   logic signed [10:0] err_q, err_d;
   logic [9:0]        cnt_q, cnt_d;
   logic [DW-1:0]     div_q, div_d;
   logic [SW-1:0]     set_q, set_d;
   logic              pen_q, pen_d;
   logic              dirx_q, dirx_d;
   logic              diry_q, diry_d;

   logic [8:0]         tx_c, ty_c;
   logic signed [9:0]  difx, dify;
   logic signed [9:0]  adx, ady;
   logic [9:0]         steps_c;
   logic signed [11:0] e2, dx12, ndy12;
   logic signed [10:0] dx11, dy11;
   logic               sentinel;
   logic               tick_go;
   logic               bx, by;
   logic               stepx, stepy;

   // Line geometry for the CALC cycle and Bresenham decisions for MOVE.
   always_comb begin
      tx_c     = (tx_q > MAXC) ? MAXC : tx_q;
      ty_c     = (ty_q > MAXC) ? MAXC : ty_q;
      difx     = $signed({1'b0, tx_c}) - $signed({1'b0, cx_q});
      dify     = $signed({1'b0, ty_c}) - $signed({1'b0, cy_q});
      adx      = difx[9] ? -difx : difx;
      ady      = dify[9] ? -dify : dify;
      steps_c  = (adx > ady) ? adx : ady;
      sentinel = (iX == 9'd511) && (iY == 9'd511);
      e2       = $signed({err_q, 1'b0});
      dx12     = $signed({{2{dx_q[9]}}, dx_q});
      ndy12    = -$signed({{2{dy_q[9]}}, dy_q});
      dx11     = $signed({dx_q[9], dx_q});
      dy11     = $signed({dy_q[9], dy_q});
      tick_go  = (state_q == S_MOVE) && (div_q == '0) && (cnt_q != '0);
      bx       = e2 > ndy12;
      by       = e2 < dx12;
      stepx    = tick_go && bx && (cx_q != tx_q);
      stepy    = tick_go && by && (cy_q != ty_q);
   end

   // Next-state logic for the sequencer and all datapath registers.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      down_d  = down_q;
      fin_d   = fin_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      set_d   = set_q;
      pen_d   = pen_q;
      dirx_d  = dirx_q;
      diry_d  = diry_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_q) state_d = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (iDone) begin
               state_d = S_CALC;
               if (sentinel || !start_q) begin
                  tx_d   = '0;
                  ty_d   = '0;
                  down_d = 1'b0;
                  fin_d  = 1'b1;
               end else begin
                  tx_d   = iX;
                  ty_d   = iY;
                  down_d = iDown;
                  fin_d  = 1'b0;
               end
            end
         end
         S_CALC: begin
            tx_d  = tx_c;
            ty_d  = ty_c;
            dx_d  = adx;
            dy_d  = ady;
            err_d = $signed({adx[9], adx}) - $signed({ady[9], ady});
            cnt_d = steps_c;
            div_d = '0;
            set_d = '0;
            if (difx > 10'sd0) dirx_d = 1'b1;
            else if (difx < 10'sd0) dirx_d = 1'b0;
            if (dify > 10'sd0) diry_d = 1'b1;
            else if (dify < 10'sd0) diry_d = 1'b0;
            if (down_q != pen_q) begin
               pen_d   = down_q;
               state_d = S_PEN;
            end else if (fin_q && !HOME) begin
               state_d = S_FIN;
            end else begin
               state_d = S_MOVE;
            end
         end
         S_PEN: begin
            if (set_q == SET_LAST) begin
               state_d = (fin_q && !HOME) ? S_FIN : S_MOVE;
            end else begin
               set_d = set_q + SW'(1);
            end
         end
         S_MOVE: begin
            if (tick_go) begin
               cnt_d = cnt_q - 10'd1;
               err_d = err_q - (bx ? dy11 : 11'sd0) + (by ? dx11 : 11'sd0);
               if (stepx) cx_d = dirx_q ? cx_q + 9'd1 : cx_q - 9'd1;
               if (stepy) cy_d = diry_q ? cy_q + 9'd1 : cy_q - 9'd1;
            end
            if (cnt_q == '0 && (div_q == '0 || div_q == DIV_LAST)) begin
               state_d = fin_q ? S_FIN : S_REQ;
            end else begin
               div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            end
         end
         S_FIN: begin
            fin_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset parks the head at home, pen up.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         tx_q    <= '0;
         ty_q    <= '0;
         down_q  <= 1'b0;
         fin_q   <= 1'b0;
         cx_q    <= '0;
         cy_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         set_q   <= '0;
         pen_q   <= 1'b0;
         dirx_q  <= 1'b0;
         diry_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= iStart;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         down_q  <= down_d;
         fin_q   <= fin_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         set_q   <= set_d;
         pen_q   <= pen_d;
         dirx_q  <= dirx_d;
         diry_q  <= diry_d;
      end
   end

   assign oPOS_REQUEST = (state_q == S_REQ);
   assign oStepX       = stepx;
   assign oStepY       = stepy;
   assign oDirX        = dirx_q;
   assign oDirY        = diry_q;
   assign oPen         = pen_q;
   assign oBusy        = (state_q != S_IDLE);
   assign oFinish      = (state_q == S_FIN);

endmodule

// File: tb/tb_pos_to_stepper.sv
// Directed bench for pos_to_stepper with a short step period and pen settle.
// Expected values are hand-computed for STEP_DIV=4, PEN_SETTLE=8.
module tb_pos_to_stepper;

   logic       clk = 1'b0;
   logic       iRST;
   logic       iStart;
   logic [8:0] iX;
   logic [8:0] iY;
   logic       iDown;
   logic       iDone;
   logic       oPOS_REQUEST;
   logic       oStepX, oStepY;
   logic       oDirX, oDirY;
   logic       oPen, oBusy, oFinish;
   logic [7:0] outs;

   int n_chk  = 0;
   int n_fail = 0;
   int nx, ny, nfin, fx, lx, fy;

   always #5 clk = ~clk;

   pos_to_stepper #(
      .STEP_DIV  (4),
      .PEN_SETTLE(8),
      .MAX_COORD (449)
   ) dut (
      .iCLK        (clk),
      .iRST        (iRST),
      .iStart      (iStart),
      .oPOS_REQUEST(oPOS_REQUEST),
      .iX          (iX),
      .iY          (iY),
      .iDown       (iDown),
      .iDone       (iDone),
      .oStepX      (oStepX),
      .oStepY      (oStepY),
      .oDirX       (oDirX),
      .oDirY       (oDirY),
      .oPen        (oPen),
      .oBusy       (oBusy),
      .oFinish     (oFinish)
   );

   assign outs = {oPOS_REQUEST, oStepX, oStepY, oDirX,
                  oDirY, oPen, oBusy, oFinish};

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called while the DUT shows its request; feeds one target pulse.
   task automatic give(input int x, input int y, input int d);
      tick;
      iX    = 9'(x);
      iY    = 9'(y);
      iDown = 1'(d);
      iDone = 1'b1;
      tick;
      iDone = 1'b0;
   endtask

   // Ticks until a request (or finish) shows, tallying step pulses.
   task automatic run(input string tag, input bit stop_fin,
                      input int budget, output int k);
      bit seen;
      seen = 1'b0;
      k = 0;
      nx = 0; ny = 0; nfin = 0;
      fx = -1; lx = -1; fy = -1;
      while (!seen && k < budget) begin
         tick;
         k++;
         if (oStepX) begin
            nx++;
            if (fx < 0) fx = k;
            lx = k;
         end
         if (oStepY) begin
            ny++;
            if (fy < 0) fy = k;
         end
         if (oFinish) nfin++;
         seen = stop_fin ? oFinish : oPOS_REQUEST;
      end
      check({tag, "_seen"}, int'(seen), 1);
   endtask

   initial begin
      int k;
      int c;
      int ns;
      iRST   = 1'b1;
      iStart = 1'b1;
      iX     = '0;
      iY     = '0;
      iDown  = 1'b0;
      iDone  = 1'b0;
      tick; tick; tick;
      check("reset_outs", int'(outs), 0);
      iRST = 1'b0;
      tick;
      check("req_rel_1", int'(oPOS_REQUEST), 0);
      tick;
      check("req_rel_2", int'(oPOS_REQUEST), 1);
      check("busy_req", int'(oBusy), 1);

      give(3, 1, 0);
      run("t2", 1'b0, 40, k);
      check("t2_first_step", fx, 1);
      check("t2_req_gap", k - fx, 12);
      check("t2_x_count", nx, 3);
      check("t2_y_count", ny, 1);
      check("t2_x_span", lx - fx, 8);
      check("t2_y_period", fy - fx, 4);
      check("t2_dirx", int'(oDirX), 1);
      check("t2_diry", int'(oDirY), 1);
      check("t2_pen", int'(oPen), 0);

      give(3, 1, 1);
      run("t3", 1'b0, 40, k);
      check("t3_req_lat", k, 10);
      check("t3_x_count", nx, 0);
      check("t3_y_count", ny, 0);
      check("t3_pen", int'(oPen), 1);

      give(500, 0, 1);
      run("t4", 1'b0, 2500, k);
      check("t4_req_lat", k, 1785);
      check("t4_x_count", nx, 446);
      check("t4_y_count", ny, 1);
      check("t4_dirx", int'(oDirX), 1);
      check("t4_diry", int'(oDirY), 0);

      give(511, 511, 0);
      tick;
      check("t5_pen_up", int'(oPen), 0);
      run("t5", 1'b1, 2500, k);
`ifdef HOME_RETURN_EN
      check("t5_fin_lat", k, 1804);
      check("t5_x_count", nx, 449);
      check("t5_dirx", int'(oDirX), 0);
`else
      check("t5_fin_lat", k, 8);
      check("t5_x_count", nx, 0);
`endif
      check("t5_fin_count", nfin, 1);
      tick;
      check("t5_fin_pulse", int'(oFinish), 0);
      check("t5_idle", int'(oBusy), 0);

      run("t6_req", 1'b0, 10, k);
      check("t6_req_lat", k, 1);
      give(5, 5, 0);
      c  = 0;
      ns = 0;
      while (ns < 2 && c < 40) begin
         tick;
         c++;
         if (oStepX) ns++;
      end
      check("t6_step2", ns, 2);
      iRST = 1'b1;
      tick;
      check("t6_rst_outs", int'(outs), 0);
      iRST = 1'b0;
      tick;
      check("t6_req_rel_1", int'(oPOS_REQUEST), 0);
      tick;
      check("t6_req_rel_2", int'(oPOS_REQUEST), 1);
      give(2, 0, 0);
      run("t6b", 1'b0, 40, k);
      check("t6b_req_lat", k, 9);
      check("t6b_x_count", nx, 2);
      check("t6b_y_count", ny, 0);
      check("t6b_dirx", int'(oDirX), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
